// File: rtl/instr_fetch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_seq_pkg
// Description : Shared constants and types for the instruction fetch
//               sequencer: opcode values, program-word field positions and
//               the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_seq_pkg;

  // Program word geometry
  localparam int c_ADDR_W = 4;
  localparam int c_WORD_W = 20;

  // Field positions inside a program word
  localparam int c_HALT_BIT = 19;
  localparam int c_OPC_MSB  = 18;
  localparam int c_OPC_LSB  = 16;
  localparam int c_A_MSB    = 15;
  localparam int c_A_LSB    = 8;
  localparam int c_B_MSB    = 7;
  localparam int c_B_LSB    = 0;

  // ALU opcodes
  localparam logic [2:0] c_OP_ADD  = 3'b000;
  localparam logic [2:0] c_OP_SUB  = 3'b001;
  localparam logic [2:0] c_OP_AND  = 3'b010;
  localparam logic [2:0] c_OP_OR   = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_MUL  = 3'b101;
  localparam logic [2:0] c_OP_DIV  = 3'b110;
  localparam logic [2:0] c_OP_COMP = 3'b111;

  // Accepted-operation counter ceiling (one run covers at most 16 words)
  localparam logic [4:0] c_ISSUE_MAX = 5'd16;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_seq_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem
// Description : Program store for the fetch sequencer. Register array with a
//               synchronous write port and an asynchronous read port. No
//               reset: contents survive a sequencer reset.
// Ports       : clk            - clock
//               we/waddr/wdata - write port (written on rising edge)
//               raddr/rdata    - combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic          w_wr_ok;

  // When the array does not cover the whole address space, out-of-range
  // writes are dropped and out-of-range reads return zero.
  generate
    if (DEPTH >= (1 << AW)) begin : g_full
      assign w_wr_ok = we;
      assign rdata   = mem_q[raddr];
    end else begin : g_partial
      assign w_wr_ok = we && ({1'b0, waddr} < (AW+1)'(DEPTH));
      assign rdata   = ({1'b0, raddr} < (AW+1)'(DEPTH)) ? mem_q[raddr] : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_seq
// Description : Instruction fetch sequencer. Walks a 16-word program from
//               address 0, fetching one word and presenting it to an ALU
//               stage with a valid/ready handshake, until a word with the
//               halt flag is fetched or the last address has issued.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start               - run program from address 0 (idle/halt)
//               prog_we/addr/data   - program load port (ignored while busy)
//               issue_ready         - ALU stage accepts current operation
//               issue_valid, opcode, a, b - operation to the ALU stage
//               pc                  - current program counter
//               busy, done          - run in progress / run ended (sticky)
//               issue_count         - operations accepted this run
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [19:0] prog_data,
  input  logic        issue_ready,
  output logic        issue_valid,
  output logic [2:0]  opcode,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [3:0]  pc,
  output logic        busy,
  output logic        done,
  output logic [4:0]  issue_count
);

  localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [c_ADDR_W-1:0] pc_q, pc_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [c_WORD_W-1:0] ir_q, ir_d;

  logic [c_WORD_W-1:0] w_rdata;
  logic                w_busy;
  logic                w_mem_we;

  assign w_busy = (state_q == ST_FETCH) || (state_q == ST_ISSUE);

  // Loads are only accepted between runs; reset also blocks them so that
  // reset wins over every other request in the same cycle.
  assign w_mem_we = prog_we && !w_busy && !reset;

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (c_ADDR_W),
    .DW    (c_WORD_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (w_rdata)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ir_q    <= ir_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ir_d    = ir_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        ir_d = w_rdata;
        if (w_rdata[c_HALT_BIT]) begin
          state_d = ST_HALT;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (issue_ready) begin
          if (cnt_q != c_ISSUE_MAX) begin
            cnt_d = cnt_q + 5'd1;
          end
          // The last address ends the run in place rather than wrapping.
          if (pc_q == c_LAST_ADDR) begin
            state_d = ST_HALT;
            done_d  = 1'b1;
          end else begin
            pc_d    = pc_q + 4'd1;
            state_d = ST_FETCH;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: operation fields are forced to zero outside ISSUE.
  // --------------------------------------------------------------------------
  always_comb begin
    issue_valid = 1'b0;
    opcode      = '0;
    a           = '0;
    b           = '0;
    if (state_q == ST_ISSUE) begin
      issue_valid = 1'b1;
      opcode      = ir_q[c_OPC_MSB:c_OPC_LSB];
      a           = ir_q[c_A_MSB:c_A_LSB];
      b           = ir_q[c_B_MSB:c_B_LSB];
    end
  end

  assign pc          = pc_q;
  assign busy        = w_busy;
  assign done        = done_q;
  assign issue_count = cnt_q;

endmodule
`default_nettype wire

// File: doc/instr_fetch_seq.md
INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, meaning the number of program words; the address width is 4.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: a one-cycle request to run the program from address 0.
REQ-005 The module SHALL have port prog_we, input, 1 bit: program write strobe.
REQ-006 The module SHALL have port prog_addr, input, 4 bits: program write address.
REQ-007 The module SHALL have port prog_data, input, 20 bits: program word; [19] is the halt flag, [18:16] the opcode, [15:8] operand a, [7:0] operand b.
REQ-008 The module SHALL have port issue_ready, input, 1 bit: the downstream ALU stage accepts the current operation.
REQ-009 The module SHALL have port issue_valid, output, 1 bit: opcode/a/b are valid for the ALU stage.
REQ-010 The module SHALL have ports opcode (output, 3 bits), a (output, 8 bits) and b (output, 8 bits): the operation presented to the ALU stage.
REQ-011 The module SHALL have port pc, output, 4 bits: the current program counter.
REQ-012 The module SHALL have ports busy (output, 1 bit: a run is in progress) and done (output, 1 bit: the run has ended, sticky).
REQ-013 The module SHALL have port issue_count, output, 5 bits: the number of operations accepted in the current run.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, ISSUE and HALT.
REQ-015 IDLE or HALT with start=1 SHALL clear pc, issue_count and done, then go to FETCH.
REQ-016 FETCH SHALL register mem[pc] into the instruction register, then go to HALT if bit 19 is set, else to ISSUE.
REQ-017 ISSUE SHALL assert issue_valid and drive opcode/a/b from the instruction register.
REQ-018 In ISSUE, opcode/a/b SHALL remain stable until issue_ready=1.
REQ-019 In ISSUE with issue_ready=1, issue_count SHALL increment; if pc==15 the next state SHALL be HALT with pc held (no wrap); else pc SHALL increment and the next state SHALL be FETCH.
REQ-020 Latency: with start sampled at cycle N, issue_valid SHALL first be 1 at cycle N+2.
REQ-021 Throughput: with issue_ready held at 1, one operation SHALL issue every 2 cycles.
REQ-022 In HALT, done SHALL be 1, busy SHALL be 0 and issue_valid SHALL be 0.
REQ-023 busy SHALL be 1 exactly in FETCH and ISSUE.
REQ-024 issue_valid SHALL be 1 only in ISSUE; outside ISSUE, opcode/a/b SHALL be 0.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 prog_we SHALL write mem[prog_addr] only when busy=0; writes while busy=1 SHALL be dropped.
REQ-027 prog_we together with start in the same cycle SHALL perform the write, and the first FETCH SHALL see the new word.
REQ-028 issue_count SHALL saturate at 16.

Reset
REQ-029 reset=1 SHALL force IDLE with pc=0, issue_count=0, done=0, busy=0, issue_valid=0, opcode=0, a=0 and b=0 on the next edge, from any state including mid-ISSUE.
REQ-030 reset SHALL take priority over start and prog_we.
REQ-031 Program memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 A shared package SHALL hold the opcode constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100, MUL=101, DIV=110, COMP=111), the instruction field positions and the state encoding.
REQ-033 A single sub-module, prog_mem, SHALL hold the 16x20 register array with a synchronous write port and a read port.

Verification
REQ-034 Load {0,ADD,5,3}, {0,SUB,5,3}, {1,-,-,-}, hold issue_ready=1, pulse start -> issues opcode 000 a=5 b=3, then 001 a=5 b=3, 2 cycles apart; then done=1 and issue_count=2.
REQ-035 Backpressure: issue_ready=0 for 3 cycles during an ADD 5,3 issue -> issue_valid, opcode, a and b stay constant; pc advances only after issue_ready=1.
REQ-036 Load all 16 words with no halt flag -> 16 issues, pc ends at 15, issue_count=16, done=1, no wrap to address 0.
REQ-037 Assert reset mid-ISSUE -> next cycle IDLE with all outputs 0; start again -> the same program replays from address 0 (memory retained).
REQ-038 prog_we to address 1 while busy, and start while busy -> memory unchanged and the run is not restarted; the same write in HALT takes effect.
